// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry, pixel width and arbiter FSM states shared by the arbiter and the frame scaler
package fb_pkg;
    localparam int FB_W = 320;
    localparam int FB_H = 240;
    localparam int FB_PIXELS = FB_W * FB_H;
    localparam int AW = 17;
    localparam int RGB_W = 12;
    typedef enum logic {IDLE, CLEAR} fsm_t;
endpackage

// File: rtl/edge_detect_rise.sv
// edge_detect_rise: one-cycle rising-edge detector whose history resets high
// Ports: clk, reset (sync, active-high), d (level in), rise (d high now, low last cycle)
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic d_q, d_d;
    always_comb d_d = d;
    // History resets to 1 so a level already high at reset release is not an edge.
    always_ff @(posedge clk) d_q <= reset ? 1'b1 : d_d;
    assign rise = d && !d_q;
endmodule

// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: shares the double-banked frame-buffer RAM between display reads, renderer writes and a clear engine
// Ports: display read (disp_*), renderer write (wr_*), clear engine (clr_*), bank swap (swap_*, vblank, front_bank),
//        RAM side (mem_*, 1-cycle read latency). Priority each cycle: display > clear > renderer.
module fb_access_arbiter
    import fb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             disp_req,
    input  logic [AW-1:0]    disp_addr,
    output logic [RGB_W-1:0] disp_data,
    output logic             disp_rvalid,
    input  logic             vblank,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [RGB_W-1:0] wr_data,
    output logic             wr_drop,
    input  logic             clr_req,
    input  logic [RGB_W-1:0] clr_color,
    output logic             clr_busy,
    input  logic             swap_req,
    output logic             swap_pending,
    output logic             swap_done,
    output logic             front_bank,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW:0]      mem_addr,
    output logic [RGB_W-1:0] mem_wdata,
    input  logic [RGB_W-1:0] mem_rdata
);
    fsm_t             state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [RGB_W-1:0] color_q, color_d;
    logic             front_q, front_d, pend_q, pend_d;
    logic             rvalid_q, rvalid_d, drop_q, drop_d;
    logic             vb_rise, wr_acc, wr_in, clr_go, clr_wr, do_swap;

    edge_detect_rise u_vb_edge (.clk(clk), .reset(reset), .d(vblank), .rise(vb_rise));

    always_comb begin
        wr_ready = !reset && state_q == IDLE && !pend_q && !disp_req;
        wr_acc   = wr_valid && wr_ready;
        wr_in    = wr_addr < AW'(FB_PIXELS);
        clr_go   = state_q == IDLE && clr_req && !pend_q;
        clr_wr   = state_q == CLEAR && !disp_req;
        // A swap is held off for the whole clear, then taken on the next vblank edge.
        do_swap  = !reset && vb_rise && pend_q && state_q == IDLE;
        mem_en   = !reset && (disp_req || clr_wr || (wr_acc && wr_in));
        mem_we   = !reset && !disp_req && (clr_wr || (wr_acc && wr_in));
        mem_addr = disp_req ? {front_q, disp_addr} : clr_wr ? {~front_q, cnt_q} : {~front_q, wr_addr};
        mem_wdata = clr_wr ? color_q : wr_data;
        state_d  = state_q;
        cnt_d    = cnt_q;
        color_d  = color_q;
        if (clr_go) begin
            state_d = CLEAR;
            cnt_d   = '0;
            color_d = clr_color;
        end
        if (clr_wr) begin
            cnt_d   = cnt_q == AW'(FB_PIXELS - 1) ? '0 : cnt_q + AW'(1);
            state_d = cnt_q == AW'(FB_PIXELS - 1) ? IDLE : CLEAR;
        end
        pend_d   = (pend_q || swap_req) && !do_swap;
        front_d  = front_q ^ do_swap;
        rvalid_d = disp_req;
        drop_d   = wr_acc && !wr_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            color_q  <= '0;
            front_q  <= 1'b0;
            pend_q   <= 1'b0;
            rvalid_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            color_q  <= color_d;
            front_q  <= front_d;
            pend_q   <= pend_d;
            rvalid_q <= rvalid_d;
            drop_q   <= drop_d;
        end
    end

    assign disp_data    = mem_rdata;
    assign disp_rvalid  = rvalid_q;
    assign wr_drop      = drop_q;
    assign clr_busy     = state_q == CLEAR;
    assign swap_pending = pend_q;
    assign swap_done    = do_swap;
    assign front_bank   = front_q;
endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb_fb_access_arbiter: directed self-checking bench for fb_access_arbiter with a behavioural frame-buffer RAM
module tb_fb_access_arbiter;
    import fb_pkg::*;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             disp_req = 1'b0, vblank = 1'b0, wr_valid = 1'b0, clr_req = 1'b0, swap_req = 1'b0;
    logic [AW-1:0]    disp_addr = '0, wr_addr = '0;
    logic [RGB_W-1:0] wr_data = '0, clr_color = '0, disp_data, mem_wdata, mem_rdata;
    logic             disp_rvalid, wr_ready, wr_drop, clr_busy, swap_pending, swap_done, front_bank, mem_en, mem_we;
    logic [AW:0]      mem_addr;
    logic [RGB_W-1:0] ram [0:262143];
    int wcount = 0, b0w = 0;
    int checks = 0, passes = 0;

    fb_access_arbiter dut (
        .clk(clk), .reset(reset), .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
        .disp_rvalid(disp_rvalid), .vblank(vblank), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop), .clr_req(clr_req), .clr_color(clr_color),
        .clr_busy(clr_busy), .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
        .front_bank(front_bank), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                wcount <= wcount + 1;
                b0w <= b0w + (mem_addr[AW] ? 0 : 1);
            end else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int wc0, bw0, n, bad, sd;
        for (int i = 0; i < 262144; i++) ram[i] = 12'(i ^ 'h5A5);
        ram[5] = 12'hABC;
        disp_req = 1'b1;
        wr_valid = 1'b1;
        tick;
        tick;
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_rvalid", 32'(disp_rvalid), 0);
        chk("rst_flags", {front_bank, swap_pending, swap_done, clr_busy, wr_drop, mem_we}, 0);
        disp_req = 1'b0;
        wr_valid = 1'b0;
        reset = 1'b0;
        tick;
        disp_req = 1'b1;
        disp_addr = 17'd5;
        #1;
        chk("rd_en_we", {mem_en, mem_we}, 32'b10);
        chk("rd_addr", 32'(mem_addr), 32'h00005);
        tick;
        disp_req = 1'b0;
        chk("rd_rvalid", 32'(disp_rvalid), 1);
        chk("rd_data", 32'(disp_data), 32'hABC);
        tick;
        chk("rd_rvalid_off", 32'(disp_rvalid), 0);
        wc0 = wcount;
        wr_valid = 1'b1;
        wr_addr = 17'd100;
        wr_data = 12'h0F0;
        disp_req = 1'b1;
        #1;
        chk("wr_blocked_by_disp", 32'(wr_ready), 0);
        tick;
        disp_req = 1'b0;
        #1;
        chk("wr_ready_free", 32'(wr_ready), 1);
        chk("wr_addr_bank1", 32'(mem_addr), 32'h20064);
        tick;
        wr_valid = 1'b0;
        disp_req = 1'b1;
        tick;
        disp_req = 1'b0;
        tick;
        chk("wr_once", 32'(wcount - wc0), 1);
        chk("wr_data_ram", 32'(ram[32'h20064]), 32'h0F0);
        wc0 = wcount;
        wr_valid = 1'b1;
        wr_addr = 17'd76800;
        #1;
        chk("oor_ready", 32'(wr_ready), 1);
        chk("oor_no_en", 32'(mem_en), 0);
        tick;
        wr_valid = 1'b0;
        chk("oor_drop", 32'(wr_drop), 1);
        tick;
        chk("oor_drop_pulse", 32'(wr_drop), 0);
        chk("oor_no_write", 32'(wcount - wc0), 0);
        swap_req = 1'b1;
        tick;
        swap_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (swap_pending !== 1'b1 || swap_done !== 1'b0 || front_bank !== 1'b0) bad++;
            swap_req = (i == 20);
            tick;
        end
        swap_req = 1'b0;
        chk("swap_pending_hold", 32'(bad), 0);
        vblank = 1'b1;
        disp_req = 1'b1;
        disp_addr = 17'd7;
        #1;
        chk("swap_done_pulse", 32'(swap_done), 1);
        chk("swap_old_front_read", 32'(mem_addr), 32'h00007);
        tick;
        disp_req = 1'b0;
        chk("swap_front1", {front_bank, swap_pending, swap_done}, 32'b100);
        vblank = 1'b0;
        wr_valid = 1'b1;
        wr_addr = 17'd200;
        wr_data = 12'h456;
        #1;
        chk("post_swap_wr_bank0", 32'(mem_addr), 32'd200);
        tick;
        wr_valid = 1'b0;
        chk("post_swap_wr_data", 32'(ram[200]), 32'h456);
        swap_req = 1'b1;
        tick;
        swap_req = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rst_aborts_swap", {front_bank, swap_pending}, 0);
        tick;
        wc0 = wcount;
        bw0 = b0w;
        clr_req = 1'b1;
        swap_req = 1'b1;
        clr_color = 12'h123;
        tick;
        clr_req = 1'b0;
        swap_req = 1'b0;
        clr_color = 12'hFFF;
        chk("clr_start", {clr_busy, swap_pending}, 32'b11);
        n = 0;
        bad = 0;
        sd = 0;
        while (clr_busy && n < 80000) begin
            if (wr_ready) bad++;
            if (swap_done) sd++;
            vblank = (n >= 1000 && n < 1010);
            n++;
            tick;
        end
        chk("clr_cycles", 32'(n), 32'd76800);
        chk("clr_wr_ready_low", 32'(bad), 0);
        chk("clr_no_swap", 32'(sd), 0);
        chk("clr_state_after", {front_bank, swap_pending}, 32'b01);
        chk("clr_write_count", 32'(wcount - wc0), 32'd76800);
        chk("clr_bank0_untouched", 32'(b0w - bw0), 0);
        chk("clr_bank0_data", 32'(ram[5]), 32'hABC);
        bad = 0;
        for (int i = 0; i < 76800; i++) if (ram[131072 + i] !== 12'h123) bad++;
        chk("clr_bank1_fill", 32'(bad), 0);
        tick;
        tick;
        vblank = 1'b1;
        #1;
        chk("clr_then_swap", 32'(swap_done), 1);
        tick;
        vblank = 1'b0;
        chk("clr_then_front", {front_bank, swap_pending}, 32'b10);
        vblank = 1'b1;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        swap_req = 1'b1;
        tick;
        swap_req = 1'b0;
        sd = 0;
        repeat (5) begin
            if (swap_done) sd++;
            tick;
        end
        chk("vb_high_no_swap", 32'(sd), 0);
        chk("vb_high_state", {front_bank, swap_pending}, 32'b01);
        vblank = 1'b0;
        tick;
        vblank = 1'b1;
        #1;
        chk("vb_later_edge", 32'(swap_done), 1);
        tick;
        vblank = 1'b0;
        chk("vb_later_front", 32'(front_bank), 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
